item_display_sched: RTL
=======================

# item_display_sched

Scheduler that shares the five-digit item display between two requesters (shop-menu browser and Morse decoder result path). Accepts 3-bit item codes over valid/ready handshakes and arbitrates round-robin. Holds each accepted item on the display for a fixed dwell time, then blanks it for a fixed gap. Drives the item code into the seven-segment item decoder and filters out codes that decoder does not define (3'b010, 3'b111).

## Interface

Parameters:
- DWELL_CYCLES, default 50_000_000: cycles an item is shown (1 s at 50 MHz); must be ≥1.
- BLANK_CYCLES, default 5_000_000: blank cycles after each item; 0 allowed.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a code.
- req0_code  in  3  requester 0 item code.
- req0_ready  out  1  requester 0 handshake accept; combinational.
- req1_valid  in  1  requester 1 has a code.
- req1_code  in  3  requester 1 item code.
- req1_ready  out  1  requester 1 handshake accept; combinational.
- cancel  in  1  abort current show/gap.
- bcd  out  3  item code to decoder; registered.
- show  out  1  1 = display decoder output; 0 = top level forces all digits to 7'b1111111; registered.
- err_pulse  out  1  one-cycle flag: invalid code consumed; registered.
- busy  out  1  state ≠ IDLE.

## Operation

- States: IDLE, SHOW, GAP. Registers: state, down-counter cnt (width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)), priority pointer ptr (1 bit), bcd, show, err_pulse.
- Grant, IDLE only:
  - Both valid: requester ptr.
  - One valid: that requester.
  - None valid: no grant.
  - reqN_ready = (state==IDLE) && grant==N. Never asserted outside IDLE; at most one ready high at a time.
- Accept = reqN_valid && reqN_ready. On accept, ptr ← other requester, whether or not the code is valid.
- Accepted valid code (000,001,011,100,101,110):
  - bcd ← code, show ← 1, cnt ← DWELL_CYCLES-1, state ← SHOW.
- Accepted invalid code (010,111):
  - Dropped. err_pulse ← 1 for one cycle, bcd/show unchanged, state stays IDLE.
- SHOW: cnt decrements each cycle. At cnt==0:
  - show ← 0.
  - If BLANK_CYCLES>0: cnt ← BLANK_CYCLES-1, state ← GAP. Otherwise state ← IDLE.
- GAP: cnt decrements; at cnt==0, state ← IDLE.
- cancel in SHOW or GAP: state ← IDLE, show ← 0 next edge; wins over cnt==0 in the same cycle. cancel in IDLE is ignored; an accept in that cycle proceeds.
- bcd holds the last shown code through GAP and IDLE; only an accepted valid code changes it.
- Requester holding valid while not ready must keep code stable; no internal queueing.

## Timing

- Reset (asynchronous assert, synchronous release): state=IDLE, cnt=0, ptr=0, bcd=3'b000, show=0, err_pulse=0, busy=0.
- Reset mid-SHOW/GAP: immediate return to reset values; pending requests are not accepted until the first edge after release.
- Accept at edge k: show=1 and bcd valid from edge k (visible in cycle k+1).
- show high for exactly DWELL_CYCLES cycles; then low for exactly BLANK_CYCLES cycles in GAP.
- First IDLE cycle can accept again. Back-to-back period = DWELL_CYCLES + BLANK_CYCLES + 1 cycles.
- err_pulse high exactly the one cycle after the invalid-code accept edge. Consecutive invalid codes can be consumed every cycle.
- busy is combinational from state.

## Test plan

Run with DWELL_CYCLES=4, BLANK_CYCLES=2 unless noted.
- Reset, then req0 valid code 3'b011 → req0_ready=1 in cycle 0. bcd=011, show=1 for 4 cycles, show=0 for 2 cycles, busy=0 and ready again at cycle 7.
- req0 and req1 both held valid (codes 001/100) for 3 items after reset → displayed order 001, 100, 001 (ptr alternates from 0); ready never high for both.
- req1 code 3'b111 in IDLE → accepted, err_pulse=1 one cycle, show stays 0, bcd unchanged, ptr → 0. Then code 3'b010 next cycle → second err_pulse.
- cancel at cycle 2 of SHOW with code 101 → show=0 next cycle, state IDLE, GAP skipped, next request accepted that same IDLE cycle. cancel coincident with cnt==0 → IDLE, not GAP.
- BLANK_CYCLES=0, req0 held valid with 110 → show stays 1 except one IDLE cycle between items; period 5 cycles.
- reset_n pulsed low mid-GAP (asynchronous, off clock edge) → all outputs at reset values before the next edge; with req1 valid during reset, no accept until the first edge after release.

Source files
------------

// File: rtl/item_display_sched.sv
// Round-robin scheduler that shares the item display between two requesters,
// showing each accepted code for a fixed dwell and blanking it for a fixed gap.
`timescale 1ns/1ps
module item_display_sched #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [2:0] req0_code,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_code,
  output logic       req1_ready,
  input  logic       cancel,
  output logic [2:0] bcd,
  output logic       show,
  output logic       err_pulse,
  output logic       busy
);

  localparam int MAX_C = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Codes 010 and 111 have no glyph in the downstream item decoder.
  function automatic logic code_is_valid(input logic [2:0] code);
    return !((code == 3'b010) || (code == 3'b111));
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic [2:0]    bcd_q, bcd_d;
  logic          show_q, show_d;
  logic          err_q, err_d;

  logic          gnt_vld_s;
  logic          gnt_sel_s;
  logic [2:0]    gnt_code_s;
  logic          accept_ok_s;

  // Round-robin grant, only offered while idle; ptr breaks ties.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_sel_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_vld_s = 1'b1;
        gnt_sel_s = ptr_q;
      end else if (req0_valid) begin
        gnt_vld_s = 1'b1;
        gnt_sel_s = 1'b0;
      end else if (req1_valid) begin
        gnt_vld_s = 1'b1;
        gnt_sel_s = 1'b1;
      end else begin
        gnt_vld_s = 1'b0;
      end
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  assign req0_ready  = gnt_vld_s && !gnt_sel_s;
  assign req1_ready  = gnt_vld_s && gnt_sel_s;
  assign gnt_code_s  = gnt_sel_s ? req1_code : req0_code;
  assign accept_ok_s = gnt_vld_s && code_is_valid(gnt_code_s);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      bcd_q   <= 3'b000;
      show_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      bcd_q   <= bcd_d;
      show_q  <= show_d;
      err_q   <= err_d;
    end
  end

  // Next state and dwell/gap counter; cancel outranks counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_ok_s) begin
          state_d = ST_SHOW;
          cnt_d   = DWELL_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          if (BLANK_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = BLANK_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cancel || (cnt_q == '0)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Display outputs, error flag and pointer update; bcd only moves on a valid accept.
  always_comb begin
    bcd_d  = bcd_q;
    show_d = show_q;
    err_d  = 1'b0;
    ptr_d  = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld_s) begin
          ptr_d = ~gnt_sel_s;
          if (accept_ok_s) begin
            bcd_d  = gnt_code_s;
            show_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_SHOW: begin
        if (cancel || (cnt_q == '0)) begin
          show_d = 1'b0;
        end else begin
          show_d = 1'b1;
        end
      end
      ST_GAP:  show_d = 1'b0;
      default: show_d = 1'b0;
    endcase
  end

  assign bcd       = bcd_q;
  assign show      = show_q;
  assign err_pulse = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
